pipelined_add_cin_cout: RTL
===========================

# pipelined_add_cin_cout

Parametrised, pipelined two-operand adder/subtractor with carry-in, carry-out and signed-overflow flag. It is the successor to the fixed 8-bit single-cycle carry adder. The carry chain is split into `STAGES` equal chunks, with one register stage per chunk, so wide datapaths close timing. Operands and results move through a valid/ready elastic pipeline, which lets the block sit directly between streaming producers and consumers in the datapath.

## Interface
- `WIDTH`, 16, operand/result width in bits; must be ≥ 1.
- `STAGES`, 4, number of pipeline stages; `WIDTH % STAGES == 0` is required; `CHUNK = WIDTH/STAGES`.

- `CLK` input 1: single clock; all state updates on the rising edge.
- `RESET` input 1: synchronous, active-high reset.
- `I_VALID` input 1: input operands valid.
- `I_READY` output 1: block accepts the input this cycle.
- `I0` input `WIDTH`: operand A.
- `I1` input `WIDTH`: operand B.
- `CIN` input 1: carry-in.
- `SUB` input 1: 0 selects add, 1 selects subtract.
- `O_VALID` output 1: result valid.
- `O_READY` input 1: downstream accepts the result.
- `O` output `WIDTH`: sum/difference.
- `COUT` output 1: carry-out of the MSB.
- `V` output 1: signed (two's-complement) overflow.

## Operation
- Arithmetic is `{COUT,O} = I0 + (SUB ? ~I1 : I1) + CIN`, computed at `WIDTH+1` bits.
  - True subtraction requires `SUB=1, CIN=1`.
  - When `SUB=1`, `COUT=1` means no borrow.
- `V = (A[MSB] == B'[MSB]) && (O[MSB] != A[MSB])`, where `B' = SUB ? ~I1 : I1`.
- Stage k (0..STAGES-1) adds chunk k of A and B' plus the carry registered by stage k-1. Stage 0 uses `CIN`.
  - Each stage registers its `CHUNK`-bit sum slice and its chunk carry-out.
  - Each stage forwards the not-yet-added upper chunks of A and B', plus the already-computed lower sum slices.
  - The chunk adder is a `CHUNK+1`-bit add; bit `CHUNK` of that add is the carry into the next stage.
- The last stage drives `O` (all slices), `COUT` (its carry-out) and `V` (from the MSBs of A, B' and `O`).
- Per-stage valid bit `v[k]`. Handshake for each stage:
  - `take[S] = O_READY`.
  - Stage k loads when `load[k] = !v[k] || take[k+1]`, where `take[k+1]` means the next stage loads, or, for the last stage, `O_READY`.
  - `I_READY = load[0]`.
  - A transfer happens on `I_VALID && I_READY`.
  - A stage holds its contents when it is not loading.
- Bubbles collapse: an empty stage always accepts, even when the output is stalled.
- `I_READY` depends combinationally on `O_READY` through the chain. This path is accepted.
- `O_VALID = v[STAGES-1]`. `O`, `COUT` and `V` are held stable while `O_VALID && !O_READY`.
- `STAGES=1` degenerates to a single registered `WIDTH`-bit adder with the same handshake.

## Timing
- Reset (`RESET=1` at a rising edge):
  - all `v[k]` go to 0;
  - all data registers go to 0;
  - `O=0`, `COUT=0`, `V=0`, `O_VALID=0`.
- In the cycle after reset, `I_READY=1`.
- Reset mid-operation discards every in-flight result; no partial result appears afterwards.
- Latency: an operand accepted at edge t presents `O_VALID=1` after edge t+STAGES-1 with continuous `O_READY`, i.e. STAGES cycles from the `I_VALID` cycle to the result cycle.
- Throughput: one result per cycle while `O_READY=1`.
- Back-pressure:
  - With `O_READY=0`, the pipeline fills.
  - `I_READY` falls when all STAGES stages are valid and `O_READY=0`.
  - At most STAGES operations are in flight.
- Simultaneous events:
  - A full pipe with `O_READY=1` and `I_VALID=1` accepts a new input and retires the output on the same edge.
  - `RESET` has priority over all loads.
- Carry wrap: `0xFFFF + 0x0001` (WIDTH=16) produces `O=0x0000`, `COUT=1`, with the carry crossing every stage boundary.

## Test plan
Unless stated, `WIDTH=16`, `STAGES=4`.

1. **Reset.** Assert `RESET` for 2 cycles, then release → `O_VALID=0`, `O=0`, `COUT=0`, `V=0`, `I_READY=1`.
2. **Full carry ripple.** `I0=0xFFFF, I1=0x0001, CIN=0, SUB=0`, `O_READY=1` → 4 cycles later `O=0x0000, COUT=1, V=0`.
   - Then `0x7FFF + 0x0001` → `O=0x8000, V=1, COUT=0`.
3. **Subtract.** `I0=0x0005, I1=0x0007, SUB=1, CIN=1` → `O=0xFFFE, COUT=0` (borrow), `V=0`.
   - `0x8000 - 0x0001` → `O=0x7FFF, V=1, COUT=1`.
4. **Streaming and back-pressure.** Drive 20 random back-to-back ops.
   - Hold `O_READY=0` for 6 cycles mid-stream → `I_READY` drops after 4 accepts.
   - `O` stays stable while stalled.
   - All 20 results emerge in order and match the reference model with no loss or duplication.
   - Then randomise `I_VALID`/`O_READY` for 1000 ops, with results compared against the `{COUT,O}` and `V` formulas.
5. **Reset mid-flight.** With 3 ops in flight, assert `RESET` for 1 cycle → no `O_VALID` for those ops. The next accepted op (`0x1234 + 0x1111`) returns `O=0x2345` after 4 cycles.
6. **Parameter sweep.** Re-run scenarios 2–4 at `(WIDTH,STAGES) = (8,1), (8,8), (32,4), (64,2)` → same functional results, with latency equal to `STAGES`.

Source files
------------

// File: rtl/pipelined_add_cin_cout_if.sv
// Elastic operand/result bundle for the pipelined adder/subtractor.
// The producer/consumer side uses master; the adder uses slave.
interface pipelined_add_cin_cout_if #(
    parameter int WIDTH = 16
);
    logic             I_VALID;
    logic             I_READY;
    logic [WIDTH-1:0] I0;
    logic [WIDTH-1:0] I1;
    logic             CIN;
    logic             SUB;
    logic             O_VALID;
    logic             O_READY;
    logic [WIDTH-1:0] O;
    logic             COUT;
    logic             V;

    modport master (
        output I_VALID, I0, I1, CIN, SUB, O_READY,
        input  I_READY, O_VALID, O, COUT, V
    );

    modport slave (
        input  I_VALID, I0, I1, CIN, SUB, O_READY,
        output I_READY, O_VALID, O, COUT, V
    );
endinterface

// File: rtl/pipelined_add_cin_cout.sv
// Pipelined add/subtract with carry-in, carry-out and signed overflow.
// The carry chain is cut into STAGES chunks, one register stage per chunk.
module pipelined_add_cin_cout #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic                     CLK,
    input  logic                     RESET,
    pipelined_add_cin_cout_if.slave  bus
);
    localparam int CHUNK = WIDTH / STAGES;
    localparam int LAST  = STAGES - 1;

    // Operands are shifted down as they travel so the chunk a stage works on
    // always sits in bits [CHUNK-1:0]; sums accumulate in place.
    logic [STAGES-1:0] v_reg;
    logic [STAGES-1:0] c_reg;
    logic [WIDTH-1:0]  a_reg [STAGES];
    logic [WIDTH-1:0]  b_reg [STAGES];
    logic [WIDTH-1:0]  s_reg [STAGES];
    logic              ovf_reg;

    logic [STAGES-1:0] v_in;
    logic [STAGES-1:0] c_in;
    logic [STAGES-1:0] load;
    logic [WIDTH-1:0]  a_in   [STAGES];
    logic [WIDTH-1:0]  b_in   [STAGES];
    logic [WIDTH-1:0]  s_in   [STAGES];
    logic [WIDTH-1:0]  a_next [STAGES];
    logic [WIDTH-1:0]  b_next [STAGES];
    logic [WIDTH-1:0]  s_next [STAGES];
    logic [CHUNK:0]    chunk_sum [STAGES];
    logic              ovf_next;

    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                assign a_in[gi] = bus.I0;
                assign b_in[gi] = bus.SUB ? ~bus.I1 : bus.I1;
                assign s_in[gi] = '0;
                assign c_in[gi] = bus.CIN;
                assign v_in[gi] = bus.I_VALID;
            end else begin : g_link
                assign a_in[gi] = a_reg[gi-1];
                assign b_in[gi] = b_reg[gi-1];
                assign s_in[gi] = s_reg[gi-1];
                assign c_in[gi] = c_reg[gi-1];
                assign v_in[gi] = v_reg[gi-1];
            end

            assign chunk_sum[gi] = {1'b0, a_in[gi][CHUNK-1:0]}
                                 + {1'b0, b_in[gi][CHUNK-1:0]}
                                 + {{CHUNK{1'b0}}, c_in[gi]};
            assign a_next[gi] = a_in[gi] >> CHUNK;
            assign b_next[gi] = b_in[gi] >> CHUNK;
            // Slice bits above gi*CHUNK are still zero, so OR inserts the slice.
            assign s_next[gi] = s_in[gi]
                              | (WIDTH'(chunk_sum[gi][CHUNK-1:0]) << (gi * CHUNK));
        end
    endgenerate

    // The last stage sees the top chunk, so its bit CHUNK-1 is the word MSB.
    assign ovf_next = (a_in[LAST][CHUNK-1] == b_in[LAST][CHUNK-1])
                   && (chunk_sum[LAST][CHUNK-1] != a_in[LAST][CHUNK-1]);

    // A stage can load when empty or when everything downstream moves.
    always_comb begin
        load       = '0;
        load[LAST] = !v_reg[LAST] || bus.O_READY;
        for (int k = LAST - 1; k >= 0; k--) begin
            load[k] = !v_reg[k] || load[k+1];
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            v_reg   <= '0;
            c_reg   <= '0;
            ovf_reg <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                a_reg[k] <= '0;
                b_reg[k] <= '0;
                s_reg[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (load[k]) begin
                    v_reg[k] <= v_in[k];
                    if (v_in[k]) begin
                        a_reg[k] <= a_next[k];
                        b_reg[k] <= b_next[k];
                        s_reg[k] <= s_next[k];
                        c_reg[k] <= chunk_sum[k][CHUNK];
                    end
                end
            end
            if (load[LAST] && v_in[LAST]) begin
                ovf_reg <= ovf_next;
            end
        end
    end

    // Operand residue leaving the final stage is always zero.
    logic unused_tail;
    assign unused_tail = ^{a_reg[LAST], b_reg[LAST]};

    assign bus.I_READY = load[0];
    assign bus.O_VALID = v_reg[LAST];
    assign bus.O       = s_reg[LAST];
    assign bus.COUT    = c_reg[LAST];
    assign bus.V       = ovf_reg;
endmodule
